// File: rtl/rx_frame_assembler_if.sv
// Bundle of the Rx frame assembler's line inputs, frame state and output handshake.
interface rx_frame_assembler_if #(
  parameter int unsigned Width = 8
);
  logic             serial_in_synced;
  logic             sampling_strobe;
  logic             start_detected;
  logic [3:0]       state;
  logic [Width-1:0] rx_data;
  logic             rx_valid;
  logic             rx_ready;
  logic             parity_error;
  logic             framing_error;
  logic             overrun;

  // Assembler side.
  modport master (
    input  serial_in_synced, sampling_strobe, start_detected, rx_ready,
    output state, rx_data, rx_valid, parity_error, framing_error, overrun
  );

  // Line driver / consumer side.
  modport slave (
    output serial_in_synced, sampling_strobe, start_detected, rx_ready,
    input  state, rx_data, rx_valid, parity_error, framing_error, overrun
  );
endinterface

// File: rtl/rx_frame_assembler.sv
// UART Rx frame assembler: walks start/data/parity/stop on each sampling strobe,
// checks parity and stop bit, and offers the byte plus flags over valid/ready.
module rx_frame_assembler #(
  parameter int unsigned INPUT_DATA_WIDTH = 8,
  parameter bit          PARITY_ENABLED   = 1'b1,
  parameter bit          PARITY_ODD       = 1'b0
) (
  input logic                  clk,
  input logic                  reset,
  rx_frame_assembler_if.master bus
);
  localparam int unsigned W = INPUT_DATA_WIDTH;

  // Codes beyond StData0 depend on W, so they are derived rather than enumerated.
  localparam logic [3:0] LastDataCode = 4'(1 + W);
  localparam logic [3:0] ParityCode   = 4'(2 + W);
  localparam logic [3:0] StopCode     = 4'(3 + W);

  typedef enum logic [3:0] {
    StIdle  = 4'd0,
    StStart = 4'd1,
    StData0 = 4'd2
  } state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   shift_q, shift_d;
  logic           par_err_q, par_err_d;
  logic [W-1:0]   data_q, data_d;
  logic           valid_q, valid_d;
  logic           perr_q, perr_d;
  logic           ferr_q, ferr_d;
  logic           overrun_q, overrun_d;
  logic           frame_done;
  logic           stop_err;
  logic           parity_exp;
  logic           slot_free;

  assign parity_exp = PARITY_ODD ? ~^shift_q : ^shift_q;

  // Frame walker: state only advances, and the line is only sampled, on a strobe.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    par_err_d  = par_err_q;
    frame_done = 1'b0;
    stop_err   = 1'b0;
    if (bus.sampling_strobe) begin
      state_d = StIdle;  // illegal codes fall back to idle
      if (state_q == StIdle) begin
        if (!bus.serial_in_synced) state_d = StStart;
      end else if (state_q == StStart) begin
        if (bus.start_detected) begin
          state_d   = StData0;
          par_err_d = 1'b0;
        end
      end else if (4'(state_q) >= 4'(StData0) && 4'(state_q) <= LastDataCode) begin
        for (int unsigned i = 0; i < W; i++) begin
          if (4'(state_q) == 4'(i + 2)) shift_d[i] = bus.serial_in_synced;
        end
        if (4'(state_q) == LastDataCode) begin
          state_d = state_e'(PARITY_ENABLED ? ParityCode : StopCode);
        end else begin
          state_d = state_e'(4'(state_q) + 4'd1);
        end
      end else if (PARITY_ENABLED && 4'(state_q) == ParityCode) begin
        par_err_d = (bus.serial_in_synced != parity_exp);
        state_d   = state_e'(StopCode);
      end else if (4'(state_q) == StopCode) begin
        frame_done = 1'b1;
        stop_err   = !bus.serial_in_synced;
      end
    end
  end

  // Output slot: load on completion if free (including same-cycle consume), else flag overrun.
  always_comb begin
    slot_free = !valid_q || bus.rx_ready;
    data_d    = data_q;
    valid_d   = valid_q;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    overrun_d = 1'b0;
    if (frame_done) begin
      if (slot_free) begin
        data_d  = shift_q;
        perr_d  = par_err_q;
        ferr_d  = stop_err;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && bus.rx_ready) begin
      valid_d = 1'b0;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      par_err_q <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      par_err_q <= par_err_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      overrun_q <= overrun_d;
    end
  end

  assign bus.state         = state_q;
  assign bus.rx_data       = data_q;
  assign bus.rx_valid      = valid_q;
  assign bus.parity_error  = perr_q;
  assign bus.framing_error = ferr_q;
  assign bus.overrun       = overrun_q;
endmodule

// File: tb/tb_rx_frame_assembler.sv
// Directed bench for rx_frame_assembler (W=8, even parity, one strobe per bit).
module tb_rx_frame_assembler;
  logic clk;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  rx_frame_assembler_if #(.Width(8)) bus ();

  rx_frame_assembler #(
    .INPUT_DATA_WIDTH(8),
    .PARITY_ENABLED  (1'b1),
    .PARITY_ODD      (1'b0)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One strobe cycle with the given line level; returns at the following negedge.
  task automatic strobe_bit(input logic b);
    @(negedge clk);
    bus.serial_in_synced = b;
    bus.sampling_strobe  = 1'b1;
    @(negedge clk);
    bus.sampling_strobe  = 1'b0;
    bus.serial_in_synced = 1'b1;
  endtask

  // Start, data LSB-first and parity; stops just before the stop-bit strobe.
  task automatic send_body(input logic [7:0] d, input logic p);
    bus.start_detected = 1'b1;
    strobe_bit(1'b0);
    chk("state_start", 32'(bus.state), 32'd1);
    strobe_bit(1'b0);
    chk("state_data0", 32'(bus.state), 32'd2);
    for (int i = 0; i < 8; i++) begin
      strobe_bit(d[i]);
      chk("state_data", 32'(bus.state), 32'(3 + i));
    end
    strobe_bit(p);
    chk("state_stop", 32'(bus.state), 32'd11);
  endtask

  task automatic send_stop(input logic s);
    strobe_bit(s);
    chk("state_idle_after_stop", 32'(bus.state), 32'd0);
    bus.start_detected = 1'b0;
  endtask

  task automatic consume();
    @(negedge clk);
    bus.rx_ready = 1'b1;
    @(negedge clk);
    bus.rx_ready = 1'b0;
    chk("valid_after_consume", 32'(bus.rx_valid), 32'd0);
  endtask

  initial begin
    reset                = 1'b1;
    bus.serial_in_synced = 1'b1;
    bus.sampling_strobe  = 1'b0;
    bus.start_detected   = 1'b0;
    bus.rx_ready         = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("reset_state", 32'(bus.state), 32'd0);
    chk("reset_valid", 32'(bus.rx_valid), 32'd0);
    chk("reset_data", 32'(bus.rx_data), 32'h00);
    chk("reset_perr", 32'(bus.parity_error), 32'd0);
    chk("reset_ferr", 32'(bus.framing_error), 32'd0);
    chk("reset_overrun", 32'(bus.overrun), 32'd0);

    // 1: clean 0x55, including state hold across non-strobe cycles with the line wiggling.
    send_body(8'h55, 1'b0);
    chk("t1_valid_before_stop", 32'(bus.rx_valid), 32'd0);
    bus.serial_in_synced = 1'b0;
    repeat (2) @(negedge clk);
    chk("t1_state_hold", 32'(bus.state), 32'd11);
    send_stop(1'b1);
    chk("t1_valid", 32'(bus.rx_valid), 32'd1);
    chk("t1_data", 32'(bus.rx_data), 32'h55);
    chk("t1_perr", 32'(bus.parity_error), 32'd0);
    chk("t1_ferr", 32'(bus.framing_error), 32'd0);
    chk("t1_overrun", 32'(bus.overrun), 32'd0);
    consume();
    chk("t1_data_kept", 32'(bus.rx_data), 32'h55);

    // 2: 0xA3 with wrong parity bit.
    send_body(8'hA3, 1'b1);
    send_stop(1'b1);
    chk("t2_valid", 32'(bus.rx_valid), 32'd1);
    chk("t2_data", 32'(bus.rx_data), 32'hA3);
    chk("t2_perr", 32'(bus.parity_error), 32'd1);
    chk("t2_ferr", 32'(bus.framing_error), 32'd0);
    consume();

    // 3: 0x0F with stop bit 0 is still delivered.
    send_body(8'h0F, 1'b0);
    send_stop(1'b0);
    chk("t3_valid", 32'(bus.rx_valid), 32'd1);
    chk("t3_data", 32'(bus.rx_data), 32'h0F);
    chk("t3_perr", 32'(bus.parity_error), 32'd0);
    chk("t3_ferr", 32'(bus.framing_error), 32'd1);
    consume();

    // 4: false start.
    bus.start_detected = 1'b0;
    strobe_bit(1'b0);
    chk("t4_state_start", 32'(bus.state), 32'd1);
    strobe_bit(1'b1);
    chk("t4_state_idle", 32'(bus.state), 32'd0);
    chk("t4_valid", 32'(bus.rx_valid), 32'd0);

    // 5: overrun while the consumer stalls.
    send_body(8'h11, 1'b0);
    send_stop(1'b1);
    chk("t5_valid_first", 32'(bus.rx_valid), 32'd1);
    chk("t5_data_first", 32'(bus.rx_data), 32'h11);
    chk("t5_no_overrun_first", 32'(bus.overrun), 32'd0);
    send_body(8'h22, 1'b0);
    chk("t5_no_overrun_early", 32'(bus.overrun), 32'd0);
    send_stop(1'b1);
    chk("t5_overrun_pulse", 32'(bus.overrun), 32'd1);
    chk("t5_data_held", 32'(bus.rx_data), 32'h11);
    chk("t5_valid_held", 32'(bus.rx_valid), 32'd1);
    @(negedge clk);
    chk("t5_overrun_cleared", 32'(bus.overrun), 32'd0);
    consume();

    // 6: reset mid-frame, then a clean frame.
    bus.start_detected = 1'b1;
    strobe_bit(1'b0);
    strobe_bit(1'b0);
    strobe_bit(1'b0);
    strobe_bit(1'b0);
    strobe_bit(1'b1);
    chk("t6_state_data3", 32'(bus.state), 32'd5);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    bus.start_detected = 1'b0;
    chk("t6_state_reset", 32'(bus.state), 32'd0);
    chk("t6_valid_reset", 32'(bus.rx_valid), 32'd0);
    send_body(8'hC4, 1'b1);
    send_stop(1'b1);
    chk("t6_valid", 32'(bus.rx_valid), 32'd1);
    chk("t6_data", 32'(bus.rx_data), 32'hC4);
    chk("t6_perr", 32'(bus.parity_error), 32'd0);
    chk("t6_ferr", 32'(bus.framing_error), 32'd0);

    // 7: completion coinciding with consumption reloads and keeps valid high.
    send_body(8'h3C, 1'b0);
    @(negedge clk);
    bus.serial_in_synced = 1'b1;
    bus.sampling_strobe  = 1'b1;
    bus.rx_ready         = 1'b1;
    @(negedge clk);
    bus.sampling_strobe  = 1'b0;
    bus.rx_ready         = 1'b0;
    bus.start_detected   = 1'b0;
    chk("t7_valid", 32'(bus.rx_valid), 32'd1);
    chk("t7_data", 32'(bus.rx_data), 32'h3C);
    chk("t7_overrun", 32'(bus.overrun), 32'd0);
    consume();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
